// File: rtl/cache_data_if.sv
// Request/response bundle between the L1 pipeline and the data array controller.
// Lookup reads, line fills and store hits each use a valid/ready handshake.
interface cache_data_if;
  logic         rd_valid;
  logic         rd_ready;
  logic [9:0]   rd_set;
  logic [1:0]   rd_way;
  logic         rd_resp_valid;
  logic [511:0] rd_resp_data;
  logic         fill_valid;
  logic         fill_ready;
  logic [9:0]   fill_set;
  logic [1:0]   fill_way;
  logic [511:0] fill_data;
  logic         st_valid;
  logic         st_ready;
  logic [9:0]   st_set;
  logic [1:0]   st_way;
  logic [511:0] st_data;
  logic [3:0]   st_qmask;

  modport slave (
    input  rd_valid, rd_set, rd_way,
    input  fill_valid, fill_set, fill_way, fill_data,
    input  st_valid, st_set, st_way, st_data, st_qmask,
    output rd_ready, rd_resp_valid, rd_resp_data,
    output fill_ready, st_ready
  );

  modport master (
    output rd_valid, rd_set, rd_way,
    output fill_valid, fill_set, fill_way, fill_data,
    output st_valid, st_set, st_way, st_data, st_qmask,
    input  rd_ready, rd_resp_valid, rd_resp_data,
    input  fill_ready, st_ready
  );
endinterface

// File: rtl/cache_data_ctrl.sv
// L1 data array controller: zero-init, fill/store write arbitration,
// and pipelined way-select of the four quarter-line bank outputs.
module cache_data_ctrl #(
  parameter int NUM_SETS   = 1024,
  parameter int FAIR_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  cache_data_if.slave                 bus,
  output logic                        init_done,
  output logic [$clog2(NUM_SETS)-1:0] bank_rd_addr,
  input  logic [2047:0]               bank_rd_data,
  output logic [$clog2(NUM_SETS)+1:0] bank_wr_addr,
  output logic [511:0]                bank_wr_data,
  output logic [3:0]                  bank_wr_en
);
  localparam int SW = $clog2(NUM_SETS);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state, state_d;
  logic [SW+1:0]   init_cnt, init_cnt_d;
  logic [2:0]      fair_cnt;
  logic            run;
  logic            force_st;
  logic            fill_gnt;
  logic            st_gnt;
  logic            wr_gnt;
  logic            p1_valid;
  logic [1:0]      p1_way;
  logic [511:0]    way_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_d;
      init_cnt <= init_cnt_d;
    end
  end

  assign force_st = (fair_cnt == 3'(FAIR_LIMIT));
  assign fill_gnt = bus.fill_valid && bus.fill_ready;
  assign st_gnt   = bus.st_valid && bus.st_ready;
  assign wr_gnt   = fill_gnt || st_gnt;

  always_comb begin
    state_d        = state;
    init_cnt_d     = init_cnt;
    run            = 1'b0;
    bank_wr_en     = '0;
    bank_wr_addr   = '0;
    bank_wr_data   = '0;
    bus.fill_ready = 1'b0;
    bus.st_ready   = 1'b0;
    unique case (state)
      INIT: begin
        if (!rst) begin
          bank_wr_en   = 4'b1111;
          bank_wr_addr = init_cnt;
          init_cnt_d   = init_cnt + 1'b1;
          if (&init_cnt)
            state_d = RUN;
        end
      end
      RUN: begin
        run = !rst;
      end
      default: state_d = INIT;
    endcase
    // fill wins unless a store has been passed over FAIR_LIMIT times
    bus.fill_ready = run && !(bus.st_valid && force_st);
    bus.st_ready   = run && !(bus.fill_valid && !force_st);
    unique case (1'b1)
      fill_gnt: begin
        bank_wr_en   = 4'b1111;
        bank_wr_addr = {bus.fill_set, bus.fill_way};
        bank_wr_data = bus.fill_data;
      end
      st_gnt: begin
        bank_wr_en   = bus.st_qmask;
        bank_wr_addr = {bus.st_set, bus.st_way};
        bank_wr_data = bus.st_data;
      end
      default: ;
    endcase
  end

  assign init_done = (state == RUN) && !rst;

  always_ff @(posedge clk) begin
    if (rst)
      fair_cnt <= '0;
    else if (st_gnt || !bus.st_valid)
      fair_cnt <= '0;
    else if (fill_gnt)
      fair_cnt <= fair_cnt + 1'b1;
  end

  // banks return stale data on a same-line collision, so hold the read
  assign bus.rd_ready = run &&
    !(wr_gnt && bank_wr_addr == {bus.rd_set, bus.rd_way});
  assign bank_rd_addr = bus.rd_set;

  always_comb begin
    way_sel = '0;
    for (int q = 0; q < 4; q++)
      way_sel[q*128 +: 128] =
        bank_rd_data[q*512 + int'(p1_way)*128 +: 128];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_valid          <= 1'b0;
      p1_way            <= '0;
      bus.rd_resp_valid <= 1'b0;
      bus.rd_resp_data  <= '0;
    end else begin
      p1_valid          <= bus.rd_valid && bus.rd_ready;
      p1_way            <= bus.rd_way;
      bus.rd_resp_valid <= p1_valid;
      if (p1_valid)
        bus.rd_resp_data <= way_sel;
    end
  end
endmodule

// File: tb/tb_cache_data_ctrl.sv
// Directed bench for cache_data_ctrl with a behavioural model of the
// four registered quarter-line banks.
module tb_cache_data_ctrl;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done;
  logic [9:0]    bank_rd_addr;
  logic [2047:0] bank_rd_data;
  logic [11:0]   bank_wr_addr;
  logic [511:0]  bank_wr_data;
  logic [3:0]    bank_wr_en;

  logic [511:0]  mem [4096];

  int n_vec = 0;
  int n_err = 0;

  cache_data_if bus ();

  cache_data_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .init_done    (init_done),
    .bank_rd_addr (bank_rd_addr),
    .bank_rd_data (bank_rd_data),
    .bank_wr_addr (bank_wr_addr),
    .bank_wr_data (bank_wr_data),
    .bank_wr_en   (bank_wr_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int q = 0; q < 4; q++)
      for (int w = 0; w < 4; w++)
        bank_rd_data[q*512 + w*128 +: 128] <=
          mem[{bank_rd_addr, 2'(w)}][q*128 +: 128];
    for (int q = 0; q < 4; q++)
      if (bank_wr_en[q])
        mem[bank_wr_addr][q*128 +: 128] <= bank_wr_data[q*128 +: 128];
  end

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [9:0] s, input logic [1:0] w,
                      input logic [511:0] d, input string tag);
    bus.fill_valid = 1'b1;
    bus.fill_set   = s;
    bus.fill_way   = w;
    bus.fill_data  = d;
    #1 chk({tag, "_fill_rdy"}, 512'(bus.fill_ready), 512'd1);
    @(negedge clk);
    bus.fill_valid = 1'b0;
  endtask

  task automatic rd(input logic [9:0] s, input logic [1:0] w,
                    input logic [511:0] exp, input string tag);
    bus.rd_valid = 1'b1;
    bus.rd_set   = s;
    bus.rd_way   = w;
    #1 chk({tag, "_rd_rdy"}, 512'(bus.rd_ready), 512'd1);
    @(negedge clk);
    bus.rd_valid = 1'b0;
    #1 chk({tag, "_lat1"}, 512'(bus.rd_resp_valid), 512'd0);
    @(negedge clk);
    #1 chk({tag, "_lat2"}, 512'(bus.rd_resp_valid), 512'd1);
    chk({tag, "_data"}, bus.rd_resp_data, exp);
  endtask

  logic [511:0] pat_a5, line7, st7, exp7, d9, d9b;
  logic [9:0]   seq10;
  logic [4:0]   seq5;
  int           bad;
  int           nresp;

  initial begin
    bus.rd_valid   = 1'b0;
    bus.rd_set     = '0;
    bus.rd_way     = '0;
    bus.fill_valid = 1'b0;
    bus.fill_set   = '0;
    bus.fill_way   = '0;
    bus.fill_data  = '0;
    bus.st_valid   = 1'b0;
    bus.st_set     = '0;
    bus.st_way     = '0;
    bus.st_data    = '0;
    bus.st_qmask   = '0;
    pat_a5 = {64{8'hA5}};
    line7  = {{32{4'h4}}, {32{4'h3}}, {32{4'h2}}, {32{4'h1}}};
    st7    = {{32{4'hD}}, {32{4'hC}}, {32{4'hB}}, {32{4'hA}}};
    exp7   = {{32{4'h4}}, {32{4'hC}}, {32{4'h2}}, {32{4'hA}}};
    d9     = {16{32'hDEAD_BEEF}};
    d9b    = {16{32'h1234_5678}};

    repeat (3) @(negedge clk);
    bus.fill_valid = 1'b1;
    bus.st_valid   = 1'b1;
    bus.rd_valid   = 1'b1;
    #1;
    chk("rst_init_done", 512'(init_done), 512'd0);
    chk("rst_readys", 512'({bus.rd_ready, bus.fill_ready, bus.st_ready}),
        512'd0);
    chk("rst_wr_en", 512'(bank_wr_en), 512'd0);
    chk("rst_resp_valid", 512'(bus.rd_resp_valid), 512'd0);
    chk("rst_resp_data", bus.rd_resp_data, 512'd0);
    bus.fill_valid = 1'b0;
    bus.st_valid   = 1'b0;
    bus.rd_valid   = 1'b0;

    @(negedge clk);
    rst = 1'b0;
    #1;
    bad = 0;
    for (int i = 0; i < 4096; i++) begin
      if (bank_wr_en !== 4'hF || bank_wr_addr !== 12'(i) ||
          init_done !== 1'b0 || bus.fill_ready !== 1'b0)
        bad++;
      @(negedge clk);
      #1;
    end
    chk("init_seq", 512'(bad), 512'd0);
    chk("init_done", 512'(init_done), 512'd1);
    chk("run_readys", 512'({bus.rd_ready, bus.fill_ready, bus.st_ready}),
        512'd7);
    chk("run_idle_wr_en", 512'(bank_wr_en), 512'd0);

    @(negedge clk);
    fill(10'd5, 2'd2, pat_a5, "f5");
    rd(10'd5, 2'd2, pat_a5, "r5w2");
    @(negedge clk);
    #1 chk("resp_hold_valid", 512'(bus.rd_resp_valid), 512'd0);
    chk("resp_hold_data", bus.rd_resp_data, pat_a5);
    rd(10'd5, 2'd1, 512'd0, "r5w1");

    @(negedge clk);
    fill(10'd7, 2'd0, line7, "f7");
    bus.st_valid = 1'b1;
    bus.st_set   = 10'd7;
    bus.st_way   = 2'd0;
    bus.st_data  = st7;
    bus.st_qmask = 4'b0101;
    #1 chk("st_ready", 512'(bus.st_ready), 512'd1);
    chk("st_wr_en", 512'(bank_wr_en), 512'(4'b0101));
    chk("st_wr_addr", 512'(bank_wr_addr), 512'({10'd7, 2'd0}));
    @(negedge clk);
    bus.st_valid = 1'b0;
    rd(10'd7, 2'd0, exp7, "r7");

    @(negedge clk);
    bus.fill_valid = 1'b1;
    bus.fill_set   = 10'd9;
    bus.fill_way   = 2'd3;
    bus.fill_data  = d9;
    bus.rd_valid   = 1'b1;
    bus.rd_set     = 10'd9;
    bus.rd_way     = 2'd3;
    #1 chk("coll_stall", 512'(bus.rd_ready), 512'd0);
    chk("coll_fill_rdy", 512'(bus.fill_ready), 512'd1);
    @(negedge clk);
    bus.fill_valid = 1'b0;
    #1 chk("coll_retry", 512'(bus.rd_ready), 512'd1);
    @(negedge clk);
    bus.rd_valid = 1'b0;
    #1 chk("coll_lat1", 512'(bus.rd_resp_valid), 512'd0);
    @(negedge clk);
    #1 chk("coll_lat2", 512'(bus.rd_resp_valid), 512'd1);
    chk("coll_data", bus.rd_resp_data, d9);

    @(negedge clk);
    bus.fill_valid = 1'b1;
    bus.fill_data  = d9b;
    bus.rd_valid   = 1'b1;
    bus.rd_way     = 2'd1;
    #1 chk("nocoll_rdy", 512'(bus.rd_ready), 512'd1);
    @(negedge clk);
    bus.fill_valid = 1'b0;
    bus.rd_valid   = 1'b0;
    @(negedge clk);
    #1 chk("nocoll_data", bus.rd_resp_data, 512'd0);
    rd(10'd9, 2'd3, d9b, "r9w3");

    @(negedge clk);
    bus.fill_valid = 1'b1;
    bus.fill_set   = 10'd100;
    bus.fill_way   = 2'd0;
    bus.fill_data  = '0;
    bus.st_valid   = 1'b1;
    bus.st_set     = 10'd101;
    bus.st_way     = 2'd0;
    bus.st_qmask   = 4'b0000;
    #1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      seq10[i] = bus.st_ready;
      if (bus.st_ready === bus.fill_ready) bad++;
      @(negedge clk);
      #1;
    end
    chk("fair_seq", 512'(seq10), 512'(10'h210));
    chk("fair_one_grant", 512'(bad), 512'd0);
    @(negedge clk);
    #1;
    bus.st_valid = 1'b0;
    @(negedge clk);
    bus.st_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      seq5[i] = bus.st_ready;
      @(negedge clk);
      #1;
    end
    chk("fair_clear", 512'(seq5), 512'(5'b10000));
    bus.fill_valid = 1'b0;
    bus.st_valid   = 1'b0;

    @(negedge clk);
    bus.rd_valid = 1'b1;
    bus.rd_set   = 10'd5;
    bus.rd_way   = 2'd2;
    repeat (3) @(negedge clk);
    bus.rd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1 chk("mid_rst_resp", 512'(bus.rd_resp_valid), 512'd0);
    rst = 1'b0;
    bus.fill_valid = 1'b1;
    #1;
    chk("reinit_addr", 512'(bank_wr_addr), 512'd0);
    chk("reinit_en", 512'(bank_wr_en), 512'hF);
    chk("reinit_fill_rdy", 512'(bus.fill_ready), 512'd0);
    nresp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (bus.rd_resp_valid) nresp++;
    end
    chk("mid_rst_no_resp", 512'(nresp), 512'd0);
    chk("reinit_addr6", 512'(bank_wr_addr), 512'd6);
    bus.fill_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
